// File: rtl/sprite_char_ctrl_if.sv
// Sprite fetch / pixel write bus of the player-character controller.
//   sprite_addr  : {row,col} address to the 1-cycle-latency sprite ROM
//   sprite_data  : ROM colour, valid one cycle after sprite_addr
//   draw_x/y     : screen coordinate of the pixel being written
//   pixel_colour : colour presented to the VGA write arbiter
//   vga_write    : write strobe for the current pixel
// master = controller, slave = ROM / VGA side.
interface sprite_char_ctrl_if #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int X_W      = 9,
  parameter int Y_W      = 8
);
  localparam int AX_W = $clog2(4 * SPRITE_W);
  localparam int AY_W = $clog2(3 * SPRITE_H);

  logic [AY_W+AX_W-1:0] sprite_addr;
  logic [5:0]           sprite_data;
  logic [X_W-1:0]       draw_x;
  logic [Y_W-1:0]       draw_y;
  logic [5:0]           pixel_colour;
  logic                 vga_write;

  modport master (
    output sprite_addr, draw_x, draw_y, pixel_colour, vga_write,
    input  sprite_data
  );

  modport slave (
    input  sprite_addr, draw_x, draw_y, pixel_colour, vga_write,
    output sprite_data
  );
endinterface

// File: rtl/sprite_char_ctrl.sv
// Player-character controller: applies one-step move/attack actions with
// collision blocking and play-field clamping, and streams the character
// sprite from an external sprite ROM to the VGA pixel writer.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   init                : reload start position, abort any draw
//   apply_action        : one-cycle pulse, apply user_input (ignored while drawing)
//   draw_start          : one-cycle pulse, start a sprite draw (IDLE only)
//   user_input[2:0]     : 001 attack, 010 up, 011 down, 100 left, 101 right
//   collision[3:0]      : blocked directions {right,left,down,up}
//   x_pos, y_pos        : character top-left position
//   facing, attacking   : character state
//   draw_busy, draw_done: draw in progress / one-cycle end-of-draw pulse
//   pix_bus             : sprite ROM and VGA pixel bus (master side)
module sprite_char_ctrl #(
  parameter int         SPRITE_W    = 16,
  parameter int         SPRITE_H    = 16,
  parameter int         X_W         = 9,
  parameter int         Y_W         = 8,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 304,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 224,
  parameter int         STEP        = 1,
  parameter int         INIT_X      = 127,
  parameter int         INIT_Y      = 88,
  parameter int         ANIM_DIV    = 8,
  parameter int         ATTACK_LEN  = 4,
  parameter logic [5:0] TRANSPARENT = 6'h3F
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               apply_action,
  input  logic               draw_start,
  input  logic [2:0]         user_input,
  input  logic [3:0]         collision,
  output logic [X_W-1:0]     x_pos,
  output logic [Y_W-1:0]     y_pos,
  output logic [1:0]         facing,
  output logic               attacking,
  output logic               draw_busy,
  output logic               draw_done,
  sprite_char_ctrl_if.master pix_bus
);
  localparam int PX_W   = $clog2(SPRITE_W);
  localparam int PY_W   = $clog2(SPRITE_H);
  localparam int N_W    = PX_W + PY_W;
  localparam int ANIM_W = $clog2(ANIM_DIV + 1);
  localparam int ATK_W  = $clog2(ATTACK_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, FLUSH = 2'd2} draw_state_t;

  // character state
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [1:0]        facing_r;
  logic              attacking_r;
  logic              frame_r;
  logic [ANIM_W-1:0] anim_cnt_r;
  logic [ATK_W-1:0]  atk_cnt_r;

  // draw engine state
  draw_state_t       state_r;
  logic [N_W-1:0]    pix_cnt_r;
  logic [X_W-1:0]    base_x_r;
  logic [Y_W-1:0]    base_y_r;
  logic [1:0]        band_r;
  logic [1:0]        face_snap_r;
  logic [N_W+3:0]    sprite_addr_r;
  logic [X_W-1:0]    draw_x_r;
  logic [Y_W-1:0]    draw_y_r;
  logic              pix_valid_r;
  logic              draw_busy_r;
  logic              draw_done_r;

  // combinational helpers
  logic [X_W:0]      x_inc_s, x_dec_s;
  logic [Y_W:0]      y_inc_s, y_dec_s;
  logic [X_W-1:0]    x_right_s, x_left_s, x_nxt_s;
  logic [Y_W-1:0]    y_down_s, y_up_s, y_nxt_s;
  logic [1:0]        face_nxt_s;
  logic              move_s, blocked_s, moved_s, act_en_s;
  logic [1:0]        band_s;
  logic [N_W-1:0]    pix_nxt_s;

  // One extra bit so stepping past either edge is detected instead of wrapping.
  assign x_inc_s   = {1'b0, x_r} + (X_W+1)'(STEP);
  assign x_dec_s   = {1'b0, x_r} - (X_W+1)'(STEP);
  assign y_inc_s   = {1'b0, y_r} + (Y_W+1)'(STEP);
  assign y_dec_s   = {1'b0, y_r} - (Y_W+1)'(STEP);
  assign x_right_s = (x_inc_s > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : x_inc_s[X_W-1:0];
  assign x_left_s  = (x_dec_s[X_W] || (x_dec_s < (X_W+1)'(X_MIN))) ? X_W'(X_MIN) : x_dec_s[X_W-1:0];
  assign y_down_s  = (y_inc_s > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : y_inc_s[Y_W-1:0];
  assign y_up_s    = (y_dec_s[Y_W] || (y_dec_s < (Y_W+1)'(Y_MIN))) ? Y_W'(Y_MIN) : y_dec_s[Y_W-1:0];

  // Decode the requested move into new facing, candidate position and block flag.
  always_comb begin
    move_s     = 1'b0;
    blocked_s  = 1'b0;
    face_nxt_s = facing_r;
    x_nxt_s    = x_r;
    y_nxt_s    = y_r;
    case (user_input)
      3'b010: begin move_s = 1'b1; face_nxt_s = 2'b00; blocked_s = collision[0]; y_nxt_s = y_up_s;    end
      3'b011: begin move_s = 1'b1; face_nxt_s = 2'b01; blocked_s = collision[1]; y_nxt_s = y_down_s;  end
      3'b100: begin move_s = 1'b1; face_nxt_s = 2'b10; blocked_s = collision[2]; x_nxt_s = x_left_s;  end
      3'b101: begin move_s = 1'b1; face_nxt_s = 2'b11; blocked_s = collision[3]; x_nxt_s = x_right_s; end
      default: begin move_s = 1'b0; end
    endcase
  end

  // A step clamped at the field edge does not count as a move for animation.
  assign moved_s   = move_s && !blocked_s && ((x_nxt_s != x_r) || (y_nxt_s != y_r));
  assign act_en_s  = apply_action && !draw_busy_r;
  assign band_s    = attacking_r ? 2'b10 : {1'b0, frame_r};
  assign pix_nxt_s = pix_cnt_r + N_W'(1);

  // Character position, facing, walk animation and attack timer.
  always_ff @(posedge clock) begin
    if (reset || init) begin
      x_r         <= X_W'(INIT_X);
      y_r         <= Y_W'(INIT_Y);
      facing_r    <= 2'b01;
      attacking_r <= 1'b0;
      frame_r     <= 1'b0;
      anim_cnt_r  <= ANIM_W'(0);
      atk_cnt_r   <= ATK_W'(0);
    end else if (act_en_s) begin
      if (attacking_r) begin
        // every pulse during an attack ticks the timer; input is ignored
        if (atk_cnt_r == ATK_W'(0)) begin
          attacking_r <= 1'b0;
        end else begin
          atk_cnt_r <= atk_cnt_r - ATK_W'(1);
        end
      end else if (user_input == 3'b001) begin
        attacking_r <= 1'b1;
        atk_cnt_r   <= ATK_W'(ATTACK_LEN - 1);
      end else if (move_s) begin
        facing_r <= face_nxt_s;
        if (moved_s) begin
          x_r <= x_nxt_s;
          y_r <= y_nxt_s;
          if (anim_cnt_r == ANIM_W'(ANIM_DIV - 1)) begin
            anim_cnt_r <= ANIM_W'(0);
            frame_r    <= ~frame_r;
          end else begin
            anim_cnt_r <= anim_cnt_r + ANIM_W'(1);
          end
        end
      end
    end
  end

  // Draw FSM: DRAW issues one ROM address per cycle, coordinates and valid
  // trail by one cycle to line up with ROM data; FLUSH covers the last pixel.
  always_ff @(posedge clock) begin
    if (reset || init) begin
      state_r       <= IDLE;
      pix_cnt_r     <= N_W'(0);
      base_x_r      <= X_W'(0);
      base_y_r      <= Y_W'(0);
      band_r        <= 2'b00;
      face_snap_r   <= 2'b00;
      sprite_addr_r <= (N_W+4)'(0);
      draw_x_r      <= X_W'(0);
      draw_y_r      <= Y_W'(0);
      pix_valid_r   <= 1'b0;
      draw_busy_r   <= 1'b0;
      draw_done_r   <= 1'b0;
    end else begin
      draw_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          pix_valid_r <= 1'b0;
          if (draw_start) begin
            // snapshot pre-action state so a same-cycle action cannot tear the sprite
            base_x_r      <= x_r;
            base_y_r      <= y_r;
            band_r        <= band_s;
            face_snap_r   <= facing_r;
            pix_cnt_r     <= N_W'(0);
            sprite_addr_r <= {band_s, PY_W'(0), facing_r, PX_W'(0)};
            draw_busy_r   <= 1'b1;
            state_r       <= DRAW;
          end
        end
        DRAW: begin
          draw_x_r    <= base_x_r + X_W'(pix_cnt_r[PX_W-1:0]);
          draw_y_r    <= base_y_r + Y_W'(pix_cnt_r[N_W-1:PX_W]);
          pix_valid_r <= 1'b1;
          if (pix_cnt_r == {N_W{1'b1}}) begin
            state_r <= FLUSH;
          end else begin
            pix_cnt_r     <= pix_nxt_s;
            sprite_addr_r <= {band_r, pix_nxt_s[N_W-1:PX_W], face_snap_r, pix_nxt_s[PX_W-1:0]};
          end
        end
        FLUSH: begin
          pix_valid_r <= 1'b0;
          draw_busy_r <= 1'b0;
          draw_done_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          pix_valid_r <= 1'b0;
          draw_busy_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign x_pos                = x_r;
  assign y_pos                = y_r;
  assign facing               = facing_r;
  assign attacking            = attacking_r;
  assign draw_busy            = draw_busy_r;
  assign draw_done            = draw_done_r;
  assign pix_bus.sprite_addr  = sprite_addr_r;
  assign pix_bus.draw_x       = draw_x_r;
  assign pix_bus.draw_y       = draw_y_r;
  assign pix_bus.pixel_colour = pix_bus.sprite_data;
  assign pix_bus.vga_write    = pix_valid_r && (pix_bus.sprite_data != TRANSPARENT);
endmodule

// File: tb/tb_sprite_char_ctrl.sv
// Directed bench for sprite_char_ctrl: scoreboard queue of expected pixel
// writes, drained by an independent monitor on every vga_write.
module tb_sprite_char_ctrl;
  logic       clock;
  logic       reset;
  logic       init;
  logic       apply_action;
  logic       draw_start;
  logic [2:0] user_input;
  logic [3:0] collision;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic [1:0] facing;
  logic       attacking;
  logic       draw_busy;
  logic       draw_done;

  localparam logic [2:0] ATTACK = 3'b001;
  localparam logic [2:0] UP     = 3'b010;
  localparam logic [2:0] LEFT   = 3'b100;
  localparam logic [2:0] RIGHT  = 3'b101;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   vectors    = 0;
  int   miscompares = 0;

  sprite_char_ctrl_if #(.SPRITE_W(16), .SPRITE_H(16), .X_W(9), .Y_W(8)) bus ();

  sprite_char_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .init         (init),
    .apply_action (apply_action),
    .draw_start   (draw_start),
    .user_input   (user_input),
    .collision    (collision),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .facing       (facing),
    .attacking    (attacking),
    .draw_busy    (draw_busy),
    .draw_done    (draw_done),
    .pix_bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // sprite ROM model: pixel (0,0) of every sprite is transparent, rest colour 05
  always @(posedge clock) begin
    bus.sprite_data <= (bus.sprite_addr[3:0] == 4'd0 && bus.sprite_addr[9:6] == 4'd0) ? 6'h3F : 6'h05;
  end

  // monitor: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (bus.vga_write === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_unexpected: got (%0d,%0d,%h) expected no write",
                 bus.draw_x, bus.draw_y, bus.pixel_colour);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.draw_x !== mon_e.x || bus.draw_y !== mon_e.y || bus.pixel_colour !== mon_e.c) begin
          miscompares++;
          $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                   bus.draw_x, bus.draw_y, bus.pixel_colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic step(input logic [2:0] ui);
    user_input   = ui;
    apply_action = 1'b1;
    @(posedge clock);
    #1;
    apply_action = 1'b0;
    user_input   = 3'b000;
  endtask

  task automatic push_pixels(input int bx, input int by, input int last_k);
    pix_t p;
    for (int k = 1; k <= last_k; k++) begin
      p.x = 9'((bx + k % 16) % 512);
      p.y = 8'((by + k / 16) % 256);
      p.c = 6'h05;
      exp_q.push_back(p);
    end
  endtask

  task automatic run_draw(input int bx, input int by, input logic [11:0] addr0, input string tag);
    int n;
    push_pixels(bx, by, 255);
    draw_start = 1'b1;
    @(posedge clock);
    #1 draw_start = 1'b0;
    check({tag, "_addr0"}, bus.sprite_addr, addr0);
    check({tag, "_busy"}, draw_busy, 1);
    n = 1;
    while (draw_done !== 1'b1 && n < 400) begin
      @(posedge clock);
      #1 n++;
    end
    check({tag, "_done_edges"}, n, 258);
    check({tag, "_busy_end"}, draw_busy, 0);
    @(posedge clock);
    #1 check({tag, "_done_pulse"}, draw_done, 0);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; init = 1'b0; apply_action = 1'b0; draw_start = 1'b0;
    user_input = 3'b000; collision = 4'b0000;
    do_reset();
    check("rst_x", x_pos, 127);
    check("rst_y", y_pos, 88);
    check("rst_facing", facing, 1);
    check("rst_attacking", attacking, 0);
    check("rst_busy", draw_busy, 0);
    check("rst_vga_write", bus.vga_write, 0);
    check("rst_done", draw_done, 0);

    // full draw from reset position, walk band 0 facing down
    run_draw(127, 88, 12'h010, "draw0");

    // attack lasts 3 further pulses, the 4th clears it, the 5th moves
    step(ATTACK);
    check("atk_on", attacking, 1);
    run_draw(127, 88, 12'h810, "draw_atk");
    for (int i = 0; i < 3; i++) begin
      step(UP);
      check("atk_hold", attacking, 1);
      check("atk_y_frozen", y_pos, 88);
      check("atk_face_frozen", facing, 1);
    end
    step(UP);
    check("atk_clear", attacking, 0);
    check("atk_clear_y", y_pos, 88);
    step(UP);
    check("post_atk_y", y_pos, 87);
    check("post_atk_face", facing, 0);

    // eight right moves toggle the walk frame once
    do_reset();
    for (int i = 0; i < 7; i++) step(RIGHT);
    check("right7_x", x_pos, 134);
    step(RIGHT);
    check("right8_x", x_pos, 135);
    check("right8_face", facing, 3);
    run_draw(135, 88, 12'h430, "draw_frame1");
    step(3'b110);
    check("nop_x", x_pos, 135);
    check("nop_face", facing, 3);

    // collision blocks the move but still turns the character
    collision = 4'b0001;
    step(UP);
    check("coll_y", y_pos, 88);
    check("coll_face", facing, 0);
    collision = 4'b0000;

    // clamp at the left and top edges
    do_reset();
    for (int i = 0; i < 127; i++) step(LEFT);
    check("left_edge_x", x_pos, 0);
    step(LEFT);
    check("clamp_left_x", x_pos, 0);
    check("clamp_left_face", facing, 2);
    for (int i = 0; i < 90; i++) step(UP);
    check("clamp_top_y", y_pos, 0);

    // abort a draw with init at pixel 100; action during draw is ignored
    do_reset();
    step(RIGHT);
    check("pre_abort_x", x_pos, 128);
    push_pixels(128, 88, 98);
    draw_start = 1'b1;
    @(posedge clock);
    #1 draw_start = 1'b0;
    repeat (49) @(posedge clock);
    #1 begin apply_action = 1'b1; user_input = RIGHT; end
    @(posedge clock);
    #1 begin apply_action = 1'b0; user_input = 3'b000; end
    check("busy_action_x", x_pos, 128);
    repeat (49) @(posedge clock);
    #1 init = 1'b1;
    @(posedge clock);
    #1 init = 1'b0;
    check("abort_busy", draw_busy, 0);
    check("abort_x", x_pos, 127);
    check("abort_y", y_pos, 88);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1 if (draw_done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_queue_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
